// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the execute-stage controller: opcodes, R-type functs,
// the FSM state type and the decode-result record.
package exec_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic       mux;
    logic [5:0] alu_op;
    logic       branch_cmp;
    logic       jump;
    logic       mem_access;
    logic       illegal;
    logic       multi;
  } dec_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational opcode/funct decoder; mult is legal only when ENABLE_MULT is set,
// otherwise it falls into the illegal class like any other unsupported funct.
module exec_decode
  import exec_ctrl_pkg::*;
#(
  parameter int ENABLE_MULT = 1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    // NOTE: assigning a full default before the case keeps every path driven, so no latch is inferred.
    dec = '0;
    case (opcode)
      OP_BEQ: begin
        dec.alu_op     = FN_SUB;
        dec.branch_cmp = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_ADDI: begin
        dec.mux    = 1'b1;
        dec.alu_op = FN_ADD;
      end
      OP_LW, OP_SW: begin
        dec.mux        = 1'b1;
        dec.alu_op     = FN_ADD;
        dec.mem_access = 1'b1;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dec.alu_op = funct;
          FN_MULT: begin
            if (ENABLE_MULT != 0) begin
              dec.alu_op = funct;
              dec.multi  = 1'b1;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fsm_exec_ctrl.sv
// Execute-stage controller: accepts one instruction in IDLE, holds its decoded
// controls registered through EXEC (latency counter for mult) and HOLD (backpressure).
module fsm_exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 6,
  parameter int MUL_LATENCY = 4,
  parameter int ENABLE_MULT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                control_mux_for_alu,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                branch_cmp,
  output logic                jump,
  output logic                mem_access,
  output logic                illegal_op,
  output logic                busy
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  dec_t             dec_in, ctrl, ctrl_nx;
  logic             accept;

  exec_decode #(
    .ENABLE_MULT(ENABLE_MULT)
  ) u_decode (
    .opcode(opcode),
    .funct (funct),
    .dec   (dec_in)
  );

  assign accept = in_valid && (state == S_IDLE);

  // NOTE: the control register is reset too, so alu_op and flags read 0 the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ctrl  <= '0;
    end else begin
      // NOTE: non-blocking updates let every register sample the pre-edge values.
      state <= state_nx;
      cnt   <= cnt_nx;
      ctrl  <= ctrl_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ctrl_nx  = ctrl;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_EXEC;
          ctrl_nx  = dec_in;
          cnt_nx   = dec_in.multi ? MUL_LOAD : '0;
        end
      end
      S_EXEC: begin
        if (ctrl.multi && (cnt != '0)) begin
          cnt_nx = cnt - 1'b1;
        end else if (out_ready) begin
          state_nx = S_IDLE;
          ctrl_nx  = '0;
        end else begin
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_nx = S_IDLE;
          ctrl_nx  = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        ctrl_nx  = '0;
      end
    endcase
  end

  // Handshake outputs are pure decodes of registered state; controls come straight from ctrl.
  always_comb begin
    in_ready            = (state == S_IDLE);
    busy                = (state != S_IDLE);
    out_valid           = ((state == S_EXEC) && (cnt == '0)) || (state == S_HOLD);
    control_mux_for_alu = ctrl.mux;
    alu_op              = ALU_OP_W'(ctrl.alu_op);
    branch_cmp          = ctrl.branch_cmp;
    jump                = ctrl.jump;
    mem_access          = ctrl.mem_access;
    illegal_op          = ctrl.illegal;
  end

endmodule

// File: tb/tb_fsm_exec_ctrl.sv
// Scoreboard bench for fsm_exec_ctrl: random instructions and backpressure,
// plus directed reset-abort and ENABLE_MULT=0 checks.
module tb_fsm_exec_ctrl;

  localparam int AW = 8;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [5:0]    opcode, funct;
  logic          control_mux_for_alu, branch_cmp, jump, mem_access, illegal_op, busy;
  logic [AW-1:0] alu_op;

  logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [5:0]    n_opcode, n_funct;
  logic          n_mux, n_branch_cmp, n_jump, n_mem_access, n_illegal_op, n_busy;
  logic [5:0]    n_alu_op;

  fsm_exec_ctrl #(.ALU_OP_W(AW), .MUL_LATENCY(ML), .ENABLE_MULT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .control_mux_for_alu(control_mux_for_alu), .alu_op(alu_op),
    .branch_cmp(branch_cmp), .jump(jump), .mem_access(mem_access),
    .illegal_op(illegal_op), .busy(busy)
  );

  fsm_exec_ctrl #(.ALU_OP_W(6), .MUL_LATENCY(ML), .ENABLE_MULT(0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .opcode(n_opcode), .funct(n_funct), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .control_mux_for_alu(n_mux), .alu_op(n_alu_op),
    .branch_cmp(n_branch_cmp), .jump(n_jump), .mem_access(n_mem_access),
    .illegal_op(n_illegal_op), .busy(n_busy)
  );

  typedef struct {
    logic          mux;
    logic [AW-1:0] alu;
    logic          br, jmp, mem, ill;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0, n_acc = 0, n_done = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] act_vec, n_act_vec;
  assign act_vec   = {control_mux_for_alu, alu_op, branch_cmp, jump, mem_access, illegal_op};
  assign n_act_vec = {n_mux, 2'b00, n_alu_op, n_branch_cmp, n_jump, n_mem_access, n_illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Reference: the instruction table, written as plain lookup with no notion of state.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input bit en_mult);
    exp_t e;
    e.mux = 1'b0; e.alu = '0; e.br = 1'b0; e.jmp = 1'b0; e.mem = 1'b0; e.ill = 1'b0;
    e.lat = 1; e.acc = 0;
    case (op)
      6'b000100: begin e.alu = 8'h22; e.br = 1'b1; end
      6'b000010: e.jmp = 1'b1;
      6'b001000: begin e.mux = 1'b1; e.alu = 8'h20; end
      6'b100011, 6'b101011: begin e.mux = 1'b1; e.alu = 8'h20; e.mem = 1'b1; end
      6'b000000: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) e.alu = {2'b00, fn};
        else if (en_mult && fn == 6'h18) begin e.alu = 8'h18; e.lat = ML; end
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [12:0] exp_vec(input exp_t e);
    return {e.mux, e.alu, e.br, e.jmp, e.mem, e.ill};
  endfunction

  task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = $urandom_range(0, 9);
    fn = 6'($urandom);
    case (k)
      0: op = 6'b000100;
      1: op = 6'b000010;
      2: op = 6'b001000;
      3: op = 6'b100011;
      4: op = 6'b101011;
      5: op = 6'b111111;
      6: op = 6'($urandom);
      default: begin
        op = 6'b000000;
        case ($urandom_range(0, 7))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          4: fn = 6'h2a;
          5, 6: fn = 6'h18;
          default: ;
        endcase
      end
    endcase
  endtask

  // Monitor: pops the scoreboard when out_valid first appears, then tracks the transaction.
  initial begin
    exp_t cur;
    bit   active = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready_vs_busy", in_ready, !busy);
        if (out_valid) begin
          if (!active) begin
            if (sb.size() == 0) begin
              fail_now("spurious_out_valid");
            end else begin
              cur    = sb.pop_front();
              active = 1'b1;
              check("latency", cyc - cur.acc, cur.lat);
            end
          end
          if (active) begin
            check("ctrl_valid", act_vec, exp_vec(cur));
            check("busy_valid", busy, 1'b1);
            if (out_ready) begin
              active = 1'b0;
              n_done++;
            end
          end
        end else if (active) begin
          fail_now("out_valid_dropped");
          active = 1'b0;
          n_done++;
        end else if (n_acc > n_done) begin
          check("busy_exec", busy, 1'b1);
          if (sb.size() > 0) check("ctrl_exec", act_vec, exp_vec(sb[0]));
        end else begin
          check("idle_busy", busy, 1'b0);
          check("idle_ctrl", act_vec, 13'd0);
        end
      end
    end
  end

  task automatic run_random(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_instr(opcode, funct);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      #1;
      if (in_valid && in_ready) begin
        e     = model(opcode, funct, 1'b1);
        e.acc = cyc;
        sb.push_back(e);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (n_acc == n_done) break;
      @(posedge clk);
    end
    check("drained", n_done, n_acc);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic nm_issue(input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e = model(op, fn, 1'b0);
    @(posedge clk);
    #1;
    check("nm_ready", n_in_ready, 1'b1);
    n_in_valid = 1'b1; n_opcode = op; n_funct = fn; n_out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    check("nm_out_valid", n_out_valid, 1'b1);
    check("nm_ctrl", n_act_vec, exp_vec(e));
    @(posedge clk);
    #1;
    check("nm_idle_busy", n_busy, 1'b0);
    check("nm_idle_valid", n_out_valid, 1'b0);
    check("nm_idle_ctrl", n_act_vec, 13'd0);
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; opcode = '0; funct = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_opcode = '0; n_funct = '0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ctrl", act_vec, 13'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    chk_en = 1'b1;

    run_random(1500);

    // Reset in the middle of a mult, while the counter sits at 2.
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", in_ready, 1'b1);
    in_valid = 1'b1; opcode = 6'b000000; funct = 6'h18; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_t1_busy", busy, 1'b1);
    check("abort_t1_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("abort_t2_valid", out_valid, 1'b0);
    check("abort_t2_alu", alu_op, 8'h18);
    rst = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_alu", alu_op, 8'h00);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end
    chk_en = 1'b1;

    run_random(300);

    nm_issue(6'b000000, 6'h18);
    nm_issue(6'b000000, 6'h22);
    nm_issue(6'b111111, 6'h00);
    nm_issue(6'b000010, 6'h18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fsm_exec_ctrl.md
Name: fsm_exec_ctrl

Overview:
Parametrised execute-stage controller for the multi-cycle MIPS core. It is the successor to the combinational step-3 decoder. Instructions are accepted over a valid/ready handshake. The block decodes opcode and funct into ALU source-mux select, alu_op and class flags, and holds those outputs registered and stable. It sequences multi-cycle ALU ops (mult) with a latency counter and presents completion on an out_valid/out_ready handshake to the writeback step.

Parameters:
ALU_OP_W, 6, width of alu_op; values are zero-extended encodings below, must be >= 6
MUL_LATENCY, 4, cycles mult occupies EXEC, must be >= 1 (1 = single-cycle behaviour)
ENABLE_MULT, 1, 1: funct 011000 is legal multi-cycle op; 0: it decodes as illegal
CNT_W, $clog2(MUL_LATENCY+1), latency counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
in_valid  in  1  instruction present
in_ready  out  1  block can accept; 1 only in IDLE
opcode  in  6  instruction [31:26]
funct  in  6  instruction [5:0], used only when opcode=000000
out_valid  out  1  execute complete, controls final
out_ready  in  1  downstream accepts completion
control_mux_for_alu  out  1  0: rt register, 1: sign-extended immediate
alu_op  out  ALU_OP_W  ALU function code
branch_cmp  out  1  beq compare in progress
jump  out  1  j instruction
mem_access  out  1  lw/sw address computation
illegal_op  out  1  unsupported opcode/funct
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=0): state=IDLE. All control outputs=0 and alu_op=0. out_valid=0, busy=0, in_ready=1 after release. Reset mid-operation aborts the instruction with no out_valid.
- States: IDLE, EXEC, HOLD. All outputs are registered. Decode happens on the accept edge.
- IDLE: in_valid&in_ready at edge T captures the decode. At T+1 state=EXEC and the control outputs are driven. cnt is loaded with MUL_LATENCY-1 for mult, 0 otherwise.
- EXEC: out_valid=1 when cnt==0; otherwise cnt decrements each cycle with out_valid=0.
  - cnt==0 & out_ready: go to IDLE next edge.
  - cnt==0 & !out_ready: go to HOLD.
- HOLD: out_valid=1 and all outputs frozen. On out_ready, go to IDLE.
- Single-cycle op latency: accept at T, out_valid at T+1. Mult: out_valid at T+MUL_LATENCY.
- On return to IDLE, control outputs clear to 0. No back-to-back accept: in_valid is ignored while busy. The earliest next accept is in the IDLE cycle.
- Decode (mux, alu_op, flags):
  - beq 000100: 0, 100010, branch_cmp
  - j 000010: 0, 000000, jump
  - addi 001000: 1, 100000
  - lw 100011 / sw 101011: 1, 100000, mem_access
  - R-type 000000: mux=0, alu_op=funct, for funct in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 011000 mult when ENABLE_MULT}
- Any other opcode, or an unsupported funct: illegal_op=1, alu_op=0, mux=0. It completes as a single-cycle op, so out_valid is still handshaked.
- Flags are mutually exclusive. alu_op upper bits beyond 6 are always 0.

Decomposition:
- Package exec_ctrl_pkg: opcode localparams (OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_LW, OP_SW), funct localparams, state enum, and a decode-result struct {mux, alu_op, branch_cmp, jump, mem_access, illegal, multi}.
- Sub-module exec_decode: purely combinational opcode/funct -> decode struct, parametrised by ENABLE_MULT. The FSM, counter and output registers stay in fsm_exec_ctrl.

Test Plan:
- Reset: drive rst=0 mid-mult (cnt=2) -> immediately out_valid=0, alu_op=0, busy=0; after release in_ready=1.
- addi: opcode=001000 accepted at T, out_ready=1 -> T+1 out_valid=1, mux=1, alu_op=100000; T+2 busy=0, outputs 0.
- R-type sub with backpressure: opcode=000000, funct=100010, out_ready=0 for 3 cycles -> out_valid held 4 cycles, alu_op=100010 stable, in_valid ignored; IDLE the cycle after out_ready=1.
- Mult, MUL_LATENCY=4: funct=011000 at T -> out_valid=0 for T+1..T+3, out_valid=1 at T+4, alu_op=011000 throughout.
- Illegal and mode: opcode=111111 -> out_valid at T+1 with illegal_op=1, alu_op=0. With ENABLE_MULT=0, funct=011000 -> illegal_op=1, single cycle.
- beq/j/lw/sw sweep back-to-back: branch_cmp, jump and mem_access each asserted exclusively. in_ready=0 whenever busy=1.
